solar_wb_responder: RTL and testbench
=====================================

SOLAR_WB_RESPONDER -- requirements
Module: solar_wb_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h3000_0000, Wishbone window base; bits [31:8] are compared.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries; power of two only.
REQ-003 SHALL have parameter SAMPLE_W, default 12, panel sample width.
REQ-004 SHALL have port wb_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle, strobe and write.
REQ-007 SHALL have ports wbs_sel_i  in  4, wbs_adr_i  in  32, wbs_dat_i  in  32  byte enables, address and write data.
REQ-008 SHALL have ports wbs_ack_o  out  1 and wbs_dat_o  out  32  acknowledge and read data.
REQ-009 SHALL have ports sample_valid_i  in  1 and sample_data_i  in  SAMPLE_W  single-cycle sample strobe and unsigned panel sample from the front end.
REQ-010 SHALL have port irq_o  out  1  level interrupt to the management core.

Function
REQ-011 SHALL use a two-state responder FSM, IDLE and ACK; IDLE->ACK when cyc&stb&(adr[31:8]==BASE_ADDR[31:8]); ACK->IDLE unconditionally.
REQ-012 SHALL perform the register read/write on the IDLE->ACK edge and assert wbs_ack_o for exactly the one ACK cycle (latency 1), with wbs_dat_o valid in that cycle and 0 otherwise.
REQ-013 SHALL never ack out-of-window addresses; in-window unmapped offsets SHALL ack, read 0, ignore writes.
REQ-014 SHALL map offsets: 0x00 CTRL RW ([0] enable, [1] fault_ie, [2] ovf_ie); 0x04 STATUS RO ([3:0] count, [4] empty, [5] full); 0x08 THRESH RW [SAMPLE_W-1:0]; 0x0C SAMPLE RO-pop ([SAMPLE_W-1:0] data, [31] valid); 0x10 IRQ_STAT W1C ([0] fault, [1] overflow).
REQ-015 SHALL apply wbs_sel_i per byte on CTRL and THRESH writes; IRQ_STAT clear uses byte 0 only.
REQ-016 SHALL accept a sample into the FIFO only when sample_valid_i=1 and CTRL.enable=1; otherwise the strobe is ignored.
REQ-017 SHALL drop the sample and set IRQ_STAT.overflow when pushing into a full FIFO.
REQ-018 SHALL, on a SAMPLE read, return head entry with valid=1 and pop; if empty, return 0 (valid=0) and leave count unchanged.
REQ-019 SHALL, on same-cycle push and pop with the FIFO non-empty, perform both and keep count unchanged, including when full.
REQ-020 SHALL set IRQ_STAT.fault when an accepted sample is strictly less than THRESH (unsigned).
REQ-021 SHALL let a same-cycle set win over a W1C clear of the same IRQ_STAT bit.
REQ-022 SHALL drive irq_o = (fault&fault_ie)|(overflow&ovf_ie), registered, one cycle after the flag update.
REQ-023 SHALL wrap read/write pointers modulo FIFO_DEPTH; count SHALL range 0..FIFO_DEPTH.

Reset
REQ-024 SHALL on wb_rst_i force FSM=IDLE, wbs_ack_o=0, wbs_dat_o=0, irq_o=0, CTRL=0, THRESH=0, IRQ_STAT=0, FIFO empty (pointers and count 0).
REQ-025 SHALL abandon an in-flight bus cycle when reset asserts mid-ACK; no ack is issued after reset release until a new strobe.

Structure
REQ-026 SHALL place register offsets, bit indices and FSM state encoding in shared package solar_pkg.
REQ-027 SHALL implement the FIFO as sub-module solar_sample_fifo (push, pop, full, empty, count); the bus decode and FSM stay in the top.

Verification
REQ-028 SHALL cover: write THRESH=0x200 with sel=4'b0011, read back -> ack after 1 cycle, data 0x0000_0200.
REQ-029 SHALL cover: CTRL=1, push samples 0x100,0x300 -> STATUS count=2; two SAMPLE reads -> 0x8000_0100, 0x8000_0300; third read -> 0x0000_0000.
REQ-030 SHALL cover: enable=1, push 9 samples into depth 8 -> full=1, overflow=1; with ovf_ie=1 irq_o=1; W1C 0x2 -> irq_o=0.
REQ-031 SHALL cover: THRESH=0x200, fault_ie=1, push 0x1FF -> fault=1, irq_o high; push 0x200 alone -> no fault.
REQ-032 SHALL cover: strobe at 0x3000_0100 (out of window) -> no ack for 10 cycles; at 0x3000_0020 -> ack, data 0.
REQ-033 SHALL cover: reset asserted during ACK with FIFO holding 3 entries -> ack drops immediately, count=0, all registers 0.

Source files
------------

// File: rtl/solar_pkg.sv
// rtl/solar_pkg.sv - shared register map, bit indices and FSM encoding for solar_wb_responder
package solar_pkg;

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_THRESH   = 8'h08;
  localparam logic [7:0] OFF_SAMPLE   = 8'h0C;
  localparam logic [7:0] OFF_IRQ_STAT = 8'h10;

  localparam int CTRL_EN       = 0;
  localparam int CTRL_FAULT_IE = 1;
  localparam int CTRL_OVF_IE   = 2;

  localparam int STAT_EMPTY = 4;
  localparam int STAT_FULL  = 5;

  localparam int IRQ_FAULT = 0;
  localparam int IRQ_OVF   = 1;

  localparam int SAMPLE_VALID_BIT = 31;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

endpackage

// File: rtl/solar_sample_fifo.sv
// rtl/solar_sample_fifo.sv - power-of-two sample FIFO; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module solar_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 12,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop,
  output logic [CNT_W-1:0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A pop frees the slot the concurrent push needs, so full only drops without one.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/solar_wb_responder.sv
// rtl/solar_wb_responder.sv - Wishbone register window over a solar panel sample FIFO
// with threshold fault and overflow interrupts.
module solar_wb_responder
  import solar_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          SAMPLE_W   = 12
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic                sample_valid_i,
  input  logic [SAMPLE_W-1:0] sample_data_i,
  output logic                irq_o
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]          r_state;
  logic                r_ack;
  logic [31:0]         r_dat;
  logic [2:0]          r_ctrl;
  logic [SAMPLE_W-1:0] r_thresh;
  logic                r_fault;
  logic                r_ovf;
  logic                r_irq;

  logic                w_go;
  logic [7:0]          w_off;
  logic                w_wr;
  logic                w_pop;
  logic                w_push;
  logic                w_fault_set;
  logic                w_ovf_set;
  logic [1:0]          w_clr;
  logic [SAMPLE_W-1:0] w_head;
  logic                w_full;
  logic                w_empty;
  logic [CNT_W-1:0]    w_count;
  logic [31:0]         w_rdata;
  logic [SAMPLE_W-1:0] w_thresh_wr;

  assign w_off       = wbs_adr_i[7:0];
  assign w_go        = (r_state == ST_IDLE) & wbs_cyc_i & wbs_stb_i &
                       (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_wr        = w_go & wbs_we_i;
  assign w_pop       = w_go & ~wbs_we_i & (w_off == OFF_SAMPLE);
  assign w_push      = sample_valid_i & r_ctrl[CTRL_EN];
  assign w_fault_set = w_push & (sample_data_i < r_thresh);
  assign w_clr       = (w_wr && w_off == OFF_IRQ_STAT && wbs_sel_i[0]) ? wbs_dat_i[1:0] : 2'b00;

  solar_sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .i_clk   (wb_clk_i),
    .i_rst   (wb_rst_i),
    .i_push  (w_push),
    .i_data  (sample_data_i),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_drop  (w_ovf_set),
    .o_count (w_count)
  );

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      OFF_CTRL:     w_rdata[2:0] = r_ctrl;
      OFF_STATUS: begin
        w_rdata[3:0]       = 4'(w_count);
        w_rdata[STAT_EMPTY] = w_empty;
        w_rdata[STAT_FULL]  = w_full;
      end
      OFF_THRESH:   w_rdata[SAMPLE_W-1:0] = r_thresh;
      OFF_SAMPLE: if (!w_empty) begin
        w_rdata[SAMPLE_W-1:0]     = w_head;
        w_rdata[SAMPLE_VALID_BIT] = 1'b1;
      end
      OFF_IRQ_STAT: w_rdata[1:0] = {r_ovf, r_fault};
      default:      w_rdata = 32'd0;
    endcase
  end

  always_comb begin
    w_thresh_wr = r_thresh;
    for (int i = 0; i < SAMPLE_W; i++) begin
      if (wbs_sel_i[i/8]) w_thresh_wr[i] = wbs_dat_i[i];
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_dat    <= 32'd0;
      r_ctrl   <= 3'd0;
      r_thresh <= '0;
      r_fault  <= 1'b0;
      r_ovf    <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      // Set terms are ORed after the clear so a same-cycle event is never lost.
      r_fault <= (r_fault & ~w_clr[IRQ_FAULT]) | w_fault_set;
      r_ovf   <= (r_ovf & ~w_clr[IRQ_OVF]) | w_ovf_set;
      r_irq   <= (r_fault & r_ctrl[CTRL_FAULT_IE]) | (r_ovf & r_ctrl[CTRL_OVF_IE]);
      if (r_state == ST_IDLE) begin
        if (w_go) begin
          r_state <= ST_ACK;
          r_ack   <= 1'b1;
          r_dat   <= wbs_we_i ? 32'd0 : w_rdata;
          if (w_wr && w_off == OFF_CTRL && wbs_sel_i[0]) r_ctrl <= wbs_dat_i[2:0];
          if (w_wr && w_off == OFF_THRESH) r_thresh <= w_thresh_wr;
        end
      end else begin
        r_state <= ST_IDLE;
        r_ack   <= 1'b0;
        r_dat   <= 32'd0;
      end
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;
  assign irq_o     = r_irq;

endmodule

// File: tb/tb_solar_wb_responder.sv
// tb/tb_solar_wb_responder.sv - directed and randomized checks of solar_wb_responder
// against a queue-based register model.
module tb_solar_wb_responder;
  localparam logic [31:0] BASE  = 32'h3000_0000;
  localparam int          DEPTH = 8;
  localparam int          SW    = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0;
  logic          stb = 1'b0;
  logic          we  = 1'b0;
  logic [3:0]    sel = 4'h0;
  logic [31:0]   adr = 32'h0;
  logic [31:0]   dati = 32'h0;
  logic          ack;
  logic [31:0]   dato;
  logic          sv = 1'b0;
  logic [SW-1:0] sd = '0;
  logic          irq;

  int checks = 0;
  int failures = 0;

  logic [SW-1:0] q[$];
  logic [2:0]    m_ctrl;
  logic [SW-1:0] m_thresh;
  logic          m_fault;
  logic          m_ovf;

  solar_wb_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .SAMPLE_W(SW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dati), .wbs_ack_o(ack), .wbs_dat_o(dato),
    .sample_valid_i(sv), .sample_data_i(sd), .irq_o(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ctrl = 3'd0; m_thresh = '0; m_fault = 1'b0; m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    logic [31:0] r;
    r = 32'd0;
    case (off)
      8'h00: r = {29'd0, m_ctrl};
      8'h04: r = {26'd0, q.size() == DEPTH, q.size() == 0, 4'(q.size())};
      8'h08: r = {20'd0, m_thresh};
      8'h0C: if (q.size() != 0) r = {1'b1, 19'd0, q[0]};
      8'h10: r = {30'd0, m_ovf, m_fault};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  // One clock edge of the model: read from pre-edge state, then pop, push, write, flags.
  task automatic model_step(input logic bus, input logic w, input logic [7:0] off,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic v, input logic [SW-1:0] smp,
                            output logic [31:0] exp);
    logic f_set, o_set;
    logic [2:0] c_pre;
    logic [SW-1:0] t_pre;
    c_pre = m_ctrl; t_pre = m_thresh;
    f_set = 1'b0; o_set = 1'b0;
    exp = (bus && !w) ? model_read(off) : 32'd0;
    if (bus && !w && off == 8'h0C && q.size() != 0) void'(q.pop_front());
    if (v && c_pre[0]) begin
      if (q.size() >= DEPTH) o_set = 1'b1;
      else q.push_back(smp);
      if (smp < t_pre) f_set = 1'b1;
    end
    if (bus && w) begin
      if (off == 8'h00 && s[0]) m_ctrl = d[2:0];
      if (off == 8'h08) begin
        if (s[0]) m_thresh[7:0] = d[7:0];
        if (s[1]) m_thresh[SW-1:8] = d[SW-1:8];
      end
      if (off == 8'h10 && s[0]) begin
        if (d[0]) m_fault = 1'b0;
        if (d[1]) m_ovf = 1'b0;
      end
    end
    m_fault = m_fault | f_set;
    m_ovf = m_ovf | o_set;
  endtask

  function automatic logic exp_irq();
    return (m_fault & m_ctrl[1]) | (m_ovf & m_ctrl[2]);
  endfunction

  // In-window bus transaction, optionally with a same-cycle sample strobe.
  task automatic bus_op(input string tag, input logic w, input logic [7:0] off,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic v, input logic [SW-1:0] smp);
    logic [31:0] exp;
    model_step(1'b1, w, off, d, s, v, smp, exp);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = BASE | {24'd0, off}; dati = d; sel = s;
    sv = v; sd = smp;
    @(posedge clk); #1;
    sv = 1'b0;
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
    check({tag, "_data"}, dato, exp);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ackdrop"}, {31'd0, ack}, 32'd0);
  endtask

  task automatic push(input logic [SW-1:0] smp);
    logic [31:0] unused;
    model_step(1'b0, 1'b0, 8'h00, 32'd0, 4'h0, 1'b1, smp, unused);
    @(negedge clk); sv = 1'b1; sd = smp;
    @(posedge clk); #1; sv = 1'b0;
  endtask

  task automatic check_irq(input string tag);
    @(posedge clk); #1;
    check(tag, {31'd0, irq}, {31'd0, exp_irq()});
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dato, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk); rst = 1'b0;

    bus_op("rd_status_reset", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("wr_thresh", 1'b1, 8'h08, 32'h200, 4'b0011, 1'b0, 0);
    bus_op("rd_thresh", 1'b0, 8'h08, 0, 4'hF, 1'b0, 0);
    bus_op("wr_thresh_b0", 1'b1, 8'h08, 32'hFFF, 4'b0001, 1'b0, 0);
    bus_op("rd_thresh_b0", 1'b0, 8'h08, 0, 4'hF, 1'b0, 0);
    bus_op("wr_thresh2", 1'b1, 8'h08, 32'h200, 4'b0011, 1'b0, 0);

    bus_op("wr_ctrl_en", 1'b1, 8'h00, 32'h1, 4'h1, 1'b0, 0);
    push(12'h100); push(12'h300);
    bus_op("rd_status2", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("rd_sample1", 1'b0, 8'h0C, 0, 4'hF, 1'b0, 0);
    bus_op("rd_sample2", 1'b0, 8'h0C, 0, 4'hF, 1'b0, 0);
    bus_op("rd_sample_empty", 1'b0, 8'h0C, 0, 4'hF, 1'b0, 0);
    bus_op("rd_status_after", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("w1c_all", 1'b1, 8'h10, 32'h3, 4'h1, 1'b0, 0);

    bus_op("wr_ctrl_ovf", 1'b1, 8'h00, 32'h5, 4'h1, 1'b0, 0);
    for (int i = 0; i < 9; i++) push(12'h300 + 12'(i));
    bus_op("rd_status_full", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("rd_irqstat_ovf", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    check_irq("irq_ovf_high");
    bus_op("pushpop_full", 1'b0, 8'h0C, 0, 4'hF, 1'b1, 12'h3AA);
    bus_op("rd_status_still_full", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("rd_irqstat_pp", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    bus_op("w1c_ovf", 1'b1, 8'h10, 32'h2, 4'h1, 1'b0, 0);
    check_irq("irq_ovf_cleared");
    for (int i = 0; i < 9; i++) bus_op("drain", 1'b0, 8'h0C, 0, 4'hF, 1'b0, 0);

    bus_op("wr_ctrl_fault", 1'b1, 8'h00, 32'h3, 4'h1, 1'b0, 0);
    push(12'h1FF);
    bus_op("rd_irqstat_fault", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    check_irq("irq_fault_high");
    bus_op("w1c_fault", 1'b1, 8'h10, 32'h1, 4'h1, 1'b0, 0);
    push(12'h200);
    bus_op("rd_irqstat_nofault", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    check_irq("irq_fault_low");
    bus_op("w1c_vs_set", 1'b1, 8'h10, 32'h1, 4'h1, 1'b1, 12'h000);
    bus_op("rd_set_wins", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    bus_op("w1c_sel0_off", 1'b1, 8'h10, 32'h1, 4'hE, 1'b0, 0);
    bus_op("rd_sel0_off", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    bus_op("wr_ctrl_off", 1'b1, 8'h00, 32'h0, 4'h1, 1'b0, 0);
    push(12'h050);
    bus_op("rd_status_disabled", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("wr_unmapped", 1'b1, 8'h20, 32'hFFFF_FFFF, 4'hF, 1'b0, 0);
    bus_op("rd_unmapped", 1'b0, 8'h20, 0, 4'hF, 1'b0, 0);

    begin
      int acks;
      acks = 0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3000_0100;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
        if (ack) acks++;
      end
      cyc = 1'b0; stb = 1'b0;
      check("out_of_window_acks", acks, 0);
    end

    bus_op("wr_thresh_rand", 1'b1, 8'h08, 32'h800, 4'h3, 1'b0, 0);
    bus_op("w1c_pre_rand", 1'b1, 8'h10, 32'h3, 4'h1, 1'b0, 0);
    for (int n = 0; n < 250; n++) begin
      int op;
      logic [7:0] off;
      op = $urandom_range(0, 7);
      case (op)
        0, 1: bus_op("rnd_sample", 1'b0, 8'h0C, 0, 4'hF, 1'($urandom_range(0, 1)), 12'($urandom));
        2: bus_op("rnd_status", 1'b0, 8'h04, 0, 4'hF, 1'($urandom_range(0, 1)), 12'($urandom));
        3: bus_op("rnd_irqstat", 1'b0, 8'h10, 0, 4'hF, 1'($urandom_range(0, 1)), 12'($urandom));
        4: bus_op("rnd_w1c", 1'b1, 8'h10, $urandom, 4'($urandom), 1'($urandom_range(0, 1)), 12'($urandom));
        5: begin
          bus_op("rnd_ctrl_wr", 1'b1, 8'h00, {29'd0, 1'($urandom), 1'($urandom), 1'b1}, 4'h1, 1'b0, 0);
          bus_op("rnd_ctrl_rd", 1'b0, 8'h00, 0, 4'hF, 1'b0, 0);
        end
        6: begin
          off = 8'($urandom_range(5, 63) * 4);
          bus_op("rnd_unmapped", 1'($urandom), off, $urandom, 4'hF, 1'($urandom_range(0, 1)), 12'($urandom));
        end
        default: push(12'($urandom));
      endcase
      if (n % 8 == 0) check_irq("rnd_irq");
    end

    bus_op("wr_ctrl_pre_rst", 1'b1, 8'h00, 32'h7, 4'h1, 1'b0, 0);
    bus_op("wr_thresh_pre_rst", 1'b1, 8'h08, 32'h123, 4'h3, 1'b0, 0);
    while (q.size() != 0) bus_op("drain_pre_rst", 1'b0, 8'h0C, 0, 4'hF, 1'b0, 0);
    push(12'h001); push(12'h002); push(12'h003);
    bus_op("rd_status3", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE | 32'h04;
    @(posedge clk); #1;
    check("mid_ack_before_rst", {31'd0, ack}, 32'd1);
    rst = 1'b1; #1;
    check("ack_drop_on_rst", {31'd0, ack}, 32'd0);
    check("dat_zero_on_rst", dato, 32'd0);
    check("irq_zero_on_rst", {31'd0, irq}, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    model_reset();
    @(negedge clk); rst = 1'b0;
    begin
      int acks;
      acks = 0;
      for (int i = 0; i < 4; i++) begin
        @(posedge clk); #1;
        if (ack) acks++;
      end
      check("no_ack_after_rst", acks, 0);
    end
    bus_op("post_rst_status", 1'b0, 8'h04, 0, 4'hF, 1'b0, 0);
    bus_op("post_rst_ctrl", 1'b0, 8'h00, 0, 4'hF, 1'b0, 0);
    bus_op("post_rst_thresh", 1'b0, 8'h08, 0, 4'hF, 1'b0, 0);
    bus_op("post_rst_irqstat", 1'b0, 8'h10, 0, 4'hF, 1'b0, 0);
    bus_op("post_rst_sample", 1'b0, 8'h0C, 0, 4'hF, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
